// File: rtl/btb_if.sv
// rtl/btb_if.sv - fetch lookup and execute update bundle for the branch target buffer
interface btb_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            lk_en;
    logic [XLEN-1:0] lk_pc;
    logic            pred_v;
    logic            pred_hit;
    logic            pred_t;
    logic [XLEN-1:0] pred_ta;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_jump;
    logic [XLEN-1:0] upd_ta;

    modport master (
        output flush, lk_en, lk_pc, upd_en, upd_pc, upd_taken, upd_jump, upd_ta,
        input  pred_v, pred_hit, pred_t, pred_ta
    );

    modport slave (
        input  flush, lk_en, lk_pc, upd_en, upd_pc, upd_taken, upd_jump, upd_ta,
        output pred_v, pred_hit, pred_t, pred_ta
    );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit counters; BTB_BYPASS_EN forwards same-cycle updates to lookup
module branch_target_buffer #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 6
) (
    input  logic  clk,
    input  logic  rst,
    btb_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             v_q   [ENTRIES];
    logic             v_d   [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [TAG_W-1:0] tag_d [ENTRIES];
    logic [XLEN-1:0]  ta_q  [ENTRIES];
    logic [XLEN-1:0]  ta_d  [ENTRIES];
    logic [1:0]       cnt_q [ENTRIES];
    logic [1:0]       cnt_d [ENTRIES];

    logic            pred_v_q, pred_v_d;
    logic            pred_hit_q, pred_hit_d;
    logic            pred_t_q, pred_t_d;
    logic [XLEN-1:0] pred_ta_q, pred_ta_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             unused_pc_bits;

    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign lk_tag = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_hit = v_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign unused_pc_bits = ^{bus.lk_pc[XLEN-1:IDX_W+TAG_W+2], bus.lk_pc[1:0],
                              bus.upd_pc[XLEN-1:IDX_W+TAG_W+2], bus.upd_pc[1:0]};

    // Table next-state: update first, flush last so it always wins.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            v_d[i]   = v_q[i];
            tag_d[i] = tag_q[i];
            ta_d[i]  = ta_q[i];
            cnt_d[i] = cnt_q[i];
        end
        if (bus.upd_en) begin
            if (up_hit) begin
                if (bus.upd_jump)
                    cnt_d[up_idx] = 2'b11;
                else if (bus.upd_taken && cnt_q[up_idx] != 2'b11)
                    cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
                else if (!bus.upd_taken && cnt_q[up_idx] != 2'b00)
                    cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
                if (bus.upd_taken)
                    ta_d[up_idx] = bus.upd_ta;
            end else if (bus.upd_taken) begin
                v_d[up_idx]   = 1'b1;
                tag_d[up_idx] = up_tag;
                ta_d[up_idx]  = bus.upd_ta;
                cnt_d[up_idx] = bus.upd_jump ? 2'b11 : 2'b10;
            end
        end
        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) v_d[i] = 1'b0;
        end
    end

    logic             rd_v;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_ta;
    logic [1:0]       rd_cnt;

`ifdef BTB_BYPASS_EN
    assign rd_v   = v_d[lk_idx];
    assign rd_tag = tag_d[lk_idx];
    assign rd_ta  = ta_d[lk_idx];
    assign rd_cnt = cnt_d[lk_idx];
`else
    assign rd_v   = v_q[lk_idx];
    assign rd_tag = tag_q[lk_idx];
    assign rd_ta  = ta_q[lk_idx];
    assign rd_cnt = cnt_q[lk_idx];
`endif

    // Prediction fields hold when no lookup is issued; only pred_v drops.
    always_comb begin
        pred_v_d   = bus.lk_en;
        pred_hit_d = pred_hit_q;
        pred_t_d   = pred_t_q;
        pred_ta_d  = pred_ta_q;
        if (bus.lk_en) begin
            pred_hit_d = rd_v && (rd_tag == lk_tag) && !bus.flush;
            pred_t_d   = pred_hit_d && rd_cnt[1];
            pred_ta_d  = pred_hit_d ? rd_ta : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v_q[i]   <= 1'b0;
                tag_q[i] <= '0;
                ta_q[i]  <= '0;
                cnt_q[i] <= 2'b01;
            end
            pred_v_q   <= 1'b0;
            pred_hit_q <= 1'b0;
            pred_t_q   <= 1'b0;
            pred_ta_q  <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                v_q[i]   <= v_d[i];
                tag_q[i] <= tag_d[i];
                ta_q[i]  <= ta_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pred_v_q   <= pred_v_d;
            pred_hit_q <= pred_hit_d;
            pred_t_q   <= pred_t_d;
            pred_ta_q  <= pred_ta_d;
        end
    end

    assign bus.pred_v   = pred_v_q;
    assign bus.pred_hit = pred_hit_q;
    assign bus.pred_t   = pred_t_q;
    assign bus.pred_ta  = pred_ta_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer (ENTRIES=8, TAG_W=6)
module tb_branch_target_buffer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_if #(.XLEN(XLEN)) bus();

    branch_target_buffer #(.XLEN(XLEN), .ENTRIES(8), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string           name;
        logic            hit;
        logic            t;
        logic [XLEN-1:0] ta;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every registered prediction is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.pred_v === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pred_v", {63'd0, bus.pred_v}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check(e.name, {bus.pred_hit, bus.pred_t, bus.pred_ta}, {e.hit, e.t, e.ta});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [XLEN-1:0] pc, input string nm,
                          input logic hit, input logic t, input logic [XLEN-1:0] ta);
        bus.lk_en = 1'b1;
        bus.lk_pc = pc;
        sb.push_back('{nm, hit, t, ta});
        step();
        bus.lk_en = 1'b0;
    endtask

    task automatic update(input logic [XLEN-1:0] pc, input logic taken,
                          input logic jump, input logic [XLEN-1:0] ta);
        bus.upd_en    = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = taken;
        bus.upd_jump  = jump;
        bus.upd_ta    = ta;
        step();
        bus.upd_en = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.lk_en = 1'b0;
        bus.lk_pc = '0;
        bus.upd_en = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_jump = 1'b0;
        bus.upd_ta = '0;

        #3;
        check("rst_pred_v", {63'd0, bus.pred_v}, 64'd0);
        check("rst_pred_fields", {bus.pred_hit, bus.pred_t, bus.pred_ta}, 64'd0);
        step();
        rst = 1'b0;
        step();

        lookup(32'h0040_0060, "cold_miss", 1'b0, 1'b0, 32'h0);

        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0084);
        lookup(32'h0040_0060, "alloc_hit", 1'b1, 1'b1, 32'h0040_0084);
        step();
        check("hold_pred_v", {63'd0, bus.pred_v}, 64'd0);
        check("hold_fields", {bus.pred_hit, bus.pred_t, bus.pred_ta}, {2'b11, 32'h0040_0084});

        update(32'h0040_0060, 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0060, "cnt_01", 1'b1, 1'b0, 32'h0040_0084);
        update(32'h0040_0060, 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0060, "cnt_00", 1'b1, 1'b0, 32'h0040_0084);
        update(32'h0040_0060, 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0060, "cnt_sat_00", 1'b1, 1'b0, 32'h0040_0084);
        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0084);
        lookup(32'h0040_0060, "cnt_up_01", 1'b1, 1'b0, 32'h0040_0084);
        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0084);
        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0084);
        lookup(32'h0040_0060, "cnt_11", 1'b1, 1'b1, 32'h0040_0084);
        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0088);
        update(32'h0040_0060, 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0060, "cnt_sat_11", 1'b1, 1'b1, 32'h0040_0088);

        bus.upd_pc = 32'h0040_0040;
        bus.upd_taken = 1'b1;
        bus.upd_ta = 32'h0040_0999;
        step();
        lookup(32'h0040_0040, "upd_en_low_ignored", 1'b0, 1'b0, 32'h0);
        update(32'h0040_0048, 1'b0, 1'b0, 32'h0040_0777);
        lookup(32'h0040_0048, "miss_not_taken_no_alloc", 1'b0, 1'b0, 32'h0);

        update(32'h0040_0014, 1'b1, 1'b0, 32'h0040_0100);
        lookup(32'h0040_0014, "conflict_first", 1'b1, 1'b1, 32'h0040_0100);
        update(32'h0040_0034, 1'b1, 1'b0, 32'h0040_0200);
        lookup(32'h0040_0014, "conflict_evicted", 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0034, "conflict_new", 1'b1, 1'b1, 32'h0040_0200);

        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h0040_0094;
        bus.upd_taken = 1'b1;
        bus.upd_jump = 1'b1;
        bus.upd_ta = 32'h0040_0300;
`ifdef BTB_BYPASS_EN
        lookup(32'h0040_0094, "collision_fwd", 1'b1, 1'b1, 32'h0040_0300);
`else
        lookup(32'h0040_0094, "collision_pre", 1'b0, 1'b0, 32'h0);
`endif
        bus.upd_en = 1'b0;
        bus.upd_jump = 1'b0;
        lookup(32'h0040_0094, "collision_after", 1'b1, 1'b1, 32'h0040_0300);

        bus.flush = 1'b1;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h0040_0020;
        bus.upd_taken = 1'b1;
        bus.upd_ta = 32'h0040_0500;
        lookup(32'h0040_0060, "flush_same_cycle", 1'b0, 1'b0, 32'h0);
        bus.flush = 1'b0;
        bus.upd_en = 1'b0;
        lookup(32'h0040_0020, "flush_beats_update", 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0094, "flush_cleared_94", 1'b0, 1'b0, 32'h0);
        lookup(32'h0040_0060, "flush_cleared_60", 1'b0, 1'b0, 32'h0);

        update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0084);
        bus.lk_en = 1'b1;
        bus.lk_pc = 32'h0040_0060;
        step();
        bus.lk_en = 1'b0;
        check("pre_rst_pred", {bus.pred_v, bus.pred_hit, bus.pred_t, bus.pred_ta}, {3'b111, 32'h0040_0084});
        #1 rst = 1'b1;
        #1;
        check("async_rst_pred_v", {63'd0, bus.pred_v}, 64'd0);
        check("async_rst_fields", {bus.pred_hit, bus.pred_t, bus.pred_ta}, 64'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_no_pred", {63'd0, bus.pred_v}, 64'd0);
        lookup(32'h0040_0060, "post_rst_miss", 1'b0, 1'b0, 32'h0);

        step();
        step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: address and target width.
REQ-002 The block SHALL have parameter ENTRIES, default 8: entry count, power of two, 2..64.
REQ-003 The block SHALL have parameter TAG_W, default 6: stored tag width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: clears all entries synchronously.
REQ-007 The block SHALL have port lk_en, input, 1 bit: lookup request.
REQ-008 The block SHALL have port lk_pc, input, XLEN bits: fetch PC to look up.
REQ-009 The block SHALL have port pred_v, output, 1 bit: prediction outputs refer to the previous lookup.
REQ-010 The block SHALL have port pred_hit, output, 1 bit: looked-up PC is present.
REQ-011 The block SHALL have port pred_t, output, 1 bit: predicted taken.
REQ-012 The block SHALL have port pred_ta, output, XLEN bits: predicted target.
REQ-013 The block SHALL have port upd_en, input, 1 bit: resolved-branch update from execute.
REQ-014 The block SHALL have port upd_pc, input, XLEN bits: PC of the resolved branch or jump.
REQ-015 The block SHALL have port upd_taken, input, 1 bit: actual outcome.
REQ-016 The block SHALL have port upd_jump, input, 1 bit: unconditional jump (jal/jalr).
REQ-017 The block SHALL have port upd_ta, input, XLEN bits: actual target.

Function
REQ-018 The block SHALL compute IDX_W = log2(ENTRIES), index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2], for both the lookup PC and the update PC.
REQ-019 Each entry SHALL hold V (1 bit), TAG (TAG_W bits), TA (XLEN bits) and a 2-bit saturating counter CNT.
REQ-020 Lookup SHALL have 1-cycle latency: lk_en at edge N registers pred_v=1, pred_hit=V&(TAG match), pred_t=pred_hit&CNT[1], and pred_ta=TA when pred_hit, else 0.
REQ-021 When lk_en=0, pred_v SHALL be 0 on the next edge and pred_hit/pred_t/pred_ta SHALL hold their values.
REQ-022 On an update hit (V=1 and tag match): upd_jump=1 SHALL force CNT=11; otherwise CNT SHALL increment on taken and decrement on not-taken, saturating at 11 and 00.
REQ-023 On an update hit with upd_taken=1, TA SHALL be overwritten with upd_ta.
REQ-024 On an update miss with upd_taken=1, the block SHALL allocate/replace the indexed entry: V=1, TAG and TA written, CNT=11 if upd_jump else 10.
REQ-025 An update miss with upd_taken=0 SHALL leave the entry unchanged.
REQ-026 On a same-cycle lookup and update to the same index, the lookup SHALL return the pre-update entry, except as REQ-032 provides.
REQ-027 flush=1 SHALL clear all V bits at the edge, SHALL override a same-cycle update, and SHALL force the lookup of that cycle to register pred_hit=0 and pred_t=0.
REQ-028 Update inputs SHALL be ignored when upd_en=0.

Reset
REQ-029 rst=1 SHALL immediately set all outputs (pred_v, pred_hit, pred_t, pred_ta) to 0, independent of clk.
REQ-030 rst=1 SHALL immediately set all V=0 and all CNT=01; TAG and TA are don't-care.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight lookup, with no prediction after release until a new lk_en.

Configuration
REQ-032 With macro BTB_BYPASS_EN defined, a same-cycle lookup and update to the same index SHALL return the post-update entry state (forwarding); without it, REQ-026 applies.

Verification
REQ-033 Bench SHALL cover reset and lookup: reset, then lk_pc=0x00400060 -> pred_v=1, pred_hit=0, pred_t=0, pred_ta=0 next cycle.
REQ-034 Bench SHALL cover allocate: upd_pc=0x00400060, taken=1, jump=0, ta=0x00400084, then lookup 0x00400060 -> hit=1, t=1 (CNT=10), ta=0x00400084.
REQ-035 Bench SHALL cover counter hysteresis: after REQ-034, two not-taken updates -> CNT 10->01->00, pred_t=0, pred_hit=1; three taken updates -> saturates at 11, pred_t=1.
REQ-036 Bench SHALL cover tag conflict: with ENTRIES=8, allocate 0x00400014, then taken update 0x00400034 (same index, different tag) -> lookup 0x00400014 hit=0, lookup 0x00400034 hit=1.
REQ-037 Bench SHALL cover same-cycle collision: lookup and jump update to 0x00400094 in one cycle -> pred_hit=0 without BTB_BYPASS_EN, pred_hit=1 with ta=upd_ta with it.
REQ-038 Bench SHALL cover flush priority: flush with a simultaneous taken update -> all subsequent lookups miss; async rst mid-lookup -> pred_v=0 immediately.
